// File: rtl/tl_ad_buffer.sv
// ---------------------------------------------------------------------------
// tl_ad_buffer
//   TileLink-UL A/D channel buffer placed just downstream of the junction bar.
//   Each direction is registered through its own DEPTH-entry FIFO. The FIFOs
//   cut every combinational ready/valid path and add exactly one cycle of
//   latency. B/C/E channels do not exist in TL-UL and are not carried.
//
// Ports
//   clock, reset              single clock, asynchronous active-high reset
//   auto_in_a_*   (A in)      A beats from the jbar; ready = A FIFO not full
//   auto_out_a_*  (A out)     head of the A FIFO towards the slave fabric
//   auto_out_d_*  (D in)      D beats from the slave; ready = D FIFO not full
//   auto_in_d_*   (D out)     head of the D FIFO back towards the jbar
// ---------------------------------------------------------------------------

// Generic ready/valid FIFO without bypass or flow-through.
//   in_valid/in_ready/in_bits     enqueue side
//   out_valid/out_ready/out_bits  dequeue side; out_bits is the entry at the
//                                 dequeue pointer and is stable while stalled
module tl_ad_buffer_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_bits,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_bits
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    enq_ptr_reg;
   logic [PW-1:0]    deq_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             enq;
   logic             deq;

   // Explicit wrap so that non-power-of-two depths never index past DEPTH-1.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // Ready depends only on the registered count: a dequeue in the same cycle
   // does not make room, which keeps in_ready free of any path from out_ready.
   assign in_ready  = (count_reg != FULL_CNT);
   assign out_valid = (count_reg != '0);
   assign enq       = in_valid & in_ready;
   assign deq       = out_valid & out_ready;
   assign out_bits  = mem[deq_ptr_reg];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         enq_ptr_reg <= '0;
         deq_ptr_reg <= '0;
         count_reg   <= '0;
      end else begin
         if (enq) begin
            enq_ptr_reg <= next_ptr(enq_ptr_reg);
         end
         if (deq) begin
            deq_ptr_reg <= next_ptr(deq_ptr_reg);
         end
         if (enq && !deq) begin
            count_reg <= count_reg + CW'(1);
         end else if (deq && !enq) begin
            count_reg <= count_reg - CW'(1);
         end
      end
   end

   // Storage is not reset; its contents are meaningless while count is 0.
   always_ff @(posedge clock) begin
      if (enq) begin
         mem[enq_ptr_reg] <= in_bits;
      end
   end

endmodule

module tl_ad_buffer #(
   parameter int DEPTH   = 2,
   // Packed payload widths; each equals the sum of its channel's field widths.
   parameter int A_WIDTH = 118,
   parameter int D_WIDTH = 80
) (
   input  logic        clock,
   input  logic        reset,

   output logic        auto_in_a_ready,
   input  logic        auto_in_a_valid,
   input  logic [2:0]  auto_in_a_bits_opcode,
   input  logic [2:0]  auto_in_a_bits_param,
   input  logic [2:0]  auto_in_a_bits_size,
   input  logic [3:0]  auto_in_a_bits_source,
   input  logic [31:0] auto_in_a_bits_address,
   input  logic [7:0]  auto_in_a_bits_mask,
   input  logic [63:0] auto_in_a_bits_data,
   input  logic        auto_in_a_bits_corrupt,

   input  logic        auto_out_a_ready,
   output logic        auto_out_a_valid,
   output logic [2:0]  auto_out_a_bits_opcode,
   output logic [2:0]  auto_out_a_bits_param,
   output logic [2:0]  auto_out_a_bits_size,
   output logic [3:0]  auto_out_a_bits_source,
   output logic [31:0] auto_out_a_bits_address,
   output logic [7:0]  auto_out_a_bits_mask,
   output logic [63:0] auto_out_a_bits_data,
   output logic        auto_out_a_bits_corrupt,

   output logic        auto_out_d_ready,
   input  logic        auto_out_d_valid,
   input  logic [2:0]  auto_out_d_bits_opcode,
   input  logic [1:0]  auto_out_d_bits_param,
   input  logic [2:0]  auto_out_d_bits_size,
   input  logic [3:0]  auto_out_d_bits_source,
   input  logic [1:0]  auto_out_d_bits_sink,
   input  logic        auto_out_d_bits_denied,
   input  logic [63:0] auto_out_d_bits_data,
   input  logic        auto_out_d_bits_corrupt,

   input  logic        auto_in_d_ready,
   output logic        auto_in_d_valid,
   output logic [2:0]  auto_in_d_bits_opcode,
   output logic [1:0]  auto_in_d_bits_param,
   output logic [2:0]  auto_in_d_bits_size,
   output logic [3:0]  auto_in_d_bits_source,
   output logic [1:0]  auto_in_d_bits_sink,
   output logic        auto_in_d_bits_denied,
   output logic [63:0] auto_in_d_bits_data,
   output logic        auto_in_d_bits_corrupt
);

   logic [A_WIDTH-1:0] a_enq_bits;
   logic [A_WIDTH-1:0] a_deq_bits;
   logic [D_WIDTH-1:0] d_enq_bits;
   logic [D_WIDTH-1:0] d_deq_bits;

   assign a_enq_bits = {auto_in_a_bits_opcode, auto_in_a_bits_param,
                        auto_in_a_bits_size, auto_in_a_bits_source,
                        auto_in_a_bits_address, auto_in_a_bits_mask,
                        auto_in_a_bits_data, auto_in_a_bits_corrupt};

   assign {auto_out_a_bits_opcode, auto_out_a_bits_param,
           auto_out_a_bits_size, auto_out_a_bits_source,
           auto_out_a_bits_address, auto_out_a_bits_mask,
           auto_out_a_bits_data, auto_out_a_bits_corrupt} = a_deq_bits;

   assign d_enq_bits = {auto_out_d_bits_opcode, auto_out_d_bits_param,
                        auto_out_d_bits_size, auto_out_d_bits_source,
                        auto_out_d_bits_sink, auto_out_d_bits_denied,
                        auto_out_d_bits_data, auto_out_d_bits_corrupt};

   assign {auto_in_d_bits_opcode, auto_in_d_bits_param,
           auto_in_d_bits_size, auto_in_d_bits_source,
           auto_in_d_bits_sink, auto_in_d_bits_denied,
           auto_in_d_bits_data, auto_in_d_bits_corrupt} = d_deq_bits;

   tl_ad_buffer_fifo #(.DEPTH(DEPTH), .WIDTH(A_WIDTH)) a_fifo (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (auto_in_a_valid),
      .in_ready  (auto_in_a_ready),
      .in_bits   (a_enq_bits),
      .out_valid (auto_out_a_valid),
      .out_ready (auto_out_a_ready),
      .out_bits  (a_deq_bits)
   );

   tl_ad_buffer_fifo #(.DEPTH(DEPTH), .WIDTH(D_WIDTH)) d_fifo (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (auto_out_d_valid),
      .in_ready  (auto_out_d_ready),
      .in_bits   (d_enq_bits),
      .out_valid (auto_in_d_valid),
      .out_ready (auto_in_d_ready),
      .out_bits  (d_deq_bits)
   );

endmodule

// File: tb/tb_tl_ad_buffer.sv
// ---------------------------------------------------------------------------
// tb_tl_ad_buffer
//   Two buffers (DEPTH=2 and DEPTH=3) are driven side by side. Channels are
//   numbered k = 2*instance + (0 for A, 1 for D). Each channel is modelled as
//   a bounded queue: it accepts while it holds fewer than DEPTH beats, offers
//   its oldest beat while non-empty, and a full queue refuses input even when
//   its head leaves in the same cycle.
// ---------------------------------------------------------------------------
module tb_tl_ad_buffer;

   logic         clock;
   logic         reset;

   logic         in_valid    [4];
   logic [117:0] in_bits     [4];
   logic         out_ready   [4];
   logic         in_ready_w  [4];
   logic         out_valid_w [4];
   logic [117:0] out_bits_w  [4];
   logic         acc         [4];

   logic [117:0] mq [4][$];
   int           sent [4];
   int           recv [4];
   int           compared;
   int           mismatched;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int DEP = (gi == 0) ? 2 : 3;
      wire         a_ready;
      wire         a_valid;
      wire         d_ready;
      wire         d_valid;
      wire [117:0] a_ob;
      wire [79:0]  d_ob;

      tl_ad_buffer #(.DEPTH(DEP)) dut (
         .clock                   (clock),
         .reset                   (reset),
         .auto_in_a_ready         (a_ready),
         .auto_in_a_valid         (in_valid[2*gi]),
         .auto_in_a_bits_opcode   (in_bits[2*gi][117:115]),
         .auto_in_a_bits_param    (in_bits[2*gi][114:112]),
         .auto_in_a_bits_size     (in_bits[2*gi][111:109]),
         .auto_in_a_bits_source   (in_bits[2*gi][108:105]),
         .auto_in_a_bits_address  (in_bits[2*gi][104:73]),
         .auto_in_a_bits_mask     (in_bits[2*gi][72:65]),
         .auto_in_a_bits_data     (in_bits[2*gi][64:1]),
         .auto_in_a_bits_corrupt  (in_bits[2*gi][0]),
         .auto_out_a_ready        (out_ready[2*gi]),
         .auto_out_a_valid        (a_valid),
         .auto_out_a_bits_opcode  (a_ob[117:115]),
         .auto_out_a_bits_param   (a_ob[114:112]),
         .auto_out_a_bits_size    (a_ob[111:109]),
         .auto_out_a_bits_source  (a_ob[108:105]),
         .auto_out_a_bits_address (a_ob[104:73]),
         .auto_out_a_bits_mask    (a_ob[72:65]),
         .auto_out_a_bits_data    (a_ob[64:1]),
         .auto_out_a_bits_corrupt (a_ob[0]),
         .auto_out_d_ready        (d_ready),
         .auto_out_d_valid        (in_valid[2*gi+1]),
         .auto_out_d_bits_opcode  (in_bits[2*gi+1][79:77]),
         .auto_out_d_bits_param   (in_bits[2*gi+1][76:75]),
         .auto_out_d_bits_size    (in_bits[2*gi+1][74:72]),
         .auto_out_d_bits_source  (in_bits[2*gi+1][71:68]),
         .auto_out_d_bits_sink    (in_bits[2*gi+1][67:66]),
         .auto_out_d_bits_denied  (in_bits[2*gi+1][65]),
         .auto_out_d_bits_data    (in_bits[2*gi+1][64:1]),
         .auto_out_d_bits_corrupt (in_bits[2*gi+1][0]),
         .auto_in_d_ready         (out_ready[2*gi+1]),
         .auto_in_d_valid         (d_valid),
         .auto_in_d_bits_opcode   (d_ob[79:77]),
         .auto_in_d_bits_param    (d_ob[76:75]),
         .auto_in_d_bits_size     (d_ob[74:72]),
         .auto_in_d_bits_source   (d_ob[71:68]),
         .auto_in_d_bits_sink     (d_ob[67:66]),
         .auto_in_d_bits_denied   (d_ob[65]),
         .auto_in_d_bits_data     (d_ob[64:1]),
         .auto_in_d_bits_corrupt  (d_ob[0])
      );

      assign in_ready_w[2*gi]    = a_ready;
      assign out_valid_w[2*gi]   = a_valid;
      assign out_bits_w[2*gi]    = a_ob;
      assign in_ready_w[2*gi+1]  = d_ready;
      assign out_valid_w[2*gi+1] = d_valid;
      assign out_bits_w[2*gi+1]  = {38'b0, d_ob};
   end

   function automatic int cap(input int k);
      return (k < 2) ? 2 : 3;
   endfunction

   function automatic logic [117:0] wmask(input int k);
      logic [117:0] m;
      m = '1;
      if ((k % 2) == 1) m = {38'b0, {80{1'b1}}};
      return m;
   endfunction

   task automatic chk(input bit ok, input string nm,
                      input logic [117:0] act, input logic [117:0] exp);
      compared++;
      if (!ok) begin
         mismatched++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Model and per-cycle comparison. Inputs change only just after a rising
   // edge, so at the falling edge they are exactly what the next edge samples.
   always @(negedge clock) begin
      bit enq;
      bit deq;
      for (int k = 0; k < 4; k++) begin
         if (reset) mq[k].delete();
         chk(out_valid_w[k] == (mq[k].size() != 0), $sformatf("ch%0d valid", k),
             118'(out_valid_w[k]), 118'(mq[k].size() != 0));
         chk(in_ready_w[k] == (mq[k].size() != cap(k)), $sformatf("ch%0d ready", k),
             118'(in_ready_w[k]), 118'(mq[k].size() != cap(k)));
         if (mq[k].size() != 0)
            chk((out_bits_w[k] & wmask(k)) == mq[k][0], $sformatf("ch%0d bits", k),
                out_bits_w[k] & wmask(k), mq[k][0]);
         acc[k] = in_valid[k] & in_ready_w[k];
         if (!reset) begin
            enq = in_valid[k] && (mq[k].size() != cap(k));
            deq = (mq[k].size() != 0) && out_ready[k];
            if (deq) begin
               void'(mq[k].pop_front());
               recv[k]++;
            end
            if (enq) begin
               mq[k].push_back(in_bits[k] & wmask(k));
               sent[k]++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   function automatic logic [117:0] a_beat(input logic [2:0] op, input logic [3:0] src,
                                           input logic [31:0] addr, input logic [63:0] data);
      return {op, 3'd0, 3'd3, src, addr, 8'hFF, data, 1'b0};
   endfunction

   function automatic logic [117:0] d_beat(input logic [63:0] data);
      return {38'b0, 3'd1, 2'd0, 3'd3, 4'd5, 2'd2, 1'b0, data, 1'b0};
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [117:0] b1, b2, b3;
      logic [127:0] r;
      int to_send [4];
      int cyc;
      bit busy;

      compared   = 0;
      mismatched = 0;
      reset      = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_valid[k]  = 1'b0;
         in_bits[k]   = '0;
         out_ready[k] = 1'b0;
         sent[k]      = 0;
         recv[k]      = 0;
         acc[k]       = 1'b0;
      end
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // Reset then idle
      chk(in_ready_w[0] == 1'b1, "idle a_ready", 118'(in_ready_w[0]), 118'(1));
      chk(in_ready_w[1] == 1'b1, "idle d_ready", 118'(in_ready_w[1]), 118'(1));
      chk(out_valid_w[0] == 1'b0, "idle a_valid", 118'(out_valid_w[0]), 118'(0));
      chk(out_valid_w[1] == 1'b0, "idle d_valid", 118'(out_valid_w[1]), 118'(0));

      // Single Get beat with the sink ready: visible for exactly one cycle
      b1 = a_beat(3'd4, 4'd3, 32'h8000_0040, 64'h1122_3344_5566_7788);
      out_ready[0] = 1'b1;
      in_valid[0]  = 1'b1;
      in_bits[0]   = b1;
      tick();
      in_valid[0] = 1'b0;
      chk(out_valid_w[0] == 1'b1, "single valid", 118'(out_valid_w[0]), 118'(1));
      chk(out_bits_w[0] == b1, "single bits", out_bits_w[0], b1);
      chk(out_bits_w[0][108:105] == 4'd3, "single source", 118'(out_bits_w[0][108:105]), 118'(3));
      tick();
      chk(out_valid_w[0] == 1'b0, "single drained", 118'(out_valid_w[0]), 118'(0));

      // Fill DEPTH=2 with the sink stalled, then dequeue while full
      b1 = a_beat(3'd4, 4'd1, 32'h0000_1000, 64'h1);
      b2 = a_beat(3'd0, 4'd2, 32'h0000_2000, 64'h2);
      b3 = a_beat(3'd1, 4'd3, 32'h0000_3000, 64'h3);
      out_ready[0] = 1'b0;
      in_valid[0]  = 1'b1;
      in_bits[0]   = b1;
      tick();
      in_bits[0] = b2;
      tick();
      chk(in_ready_w[0] == 1'b0, "full ready", 118'(in_ready_w[0]), 118'(0));
      in_bits[0] = b3;
      repeat (2) tick();
      chk(in_ready_w[0] == 1'b0, "held ready", 118'(in_ready_w[0]), 118'(0));
      chk(out_bits_w[0] == b1, "held head", out_bits_w[0], b1);
      out_ready[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;
      chk(out_bits_w[0] == b2, "deq-while-full head", out_bits_w[0], b2);
      chk(in_ready_w[0] == 1'b1, "deq-while-full ready", 118'(in_ready_w[0]), 118'(1));
      tick();
      in_valid[0] = 1'b0;
      chk(in_ready_w[0] == 1'b0, "third accepted", 118'(in_ready_w[0]), 118'(0));
      out_ready[0] = 1'b1;
      tick();
      chk(out_bits_w[0] == b3, "third order", out_bits_w[0], b3);
      tick();
      out_ready[0] = 1'b0;
      chk(out_valid_w[0] == 1'b0, "fill drained", 118'(out_valid_w[0]), 118'(0));

      // Continuous D stream on both depths: one beat per cycle, no bubbles
      out_ready[1] = 1'b1;
      out_ready[3] = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_valid[1] = 1'b1;
         in_valid[3] = 1'b1;
         in_bits[1]  = d_beat(64'(i));
         in_bits[3]  = d_beat(64'(i));
         tick();
         for (int k = 1; k < 4; k += 2) begin
            chk(out_valid_w[k] && out_bits_w[k][64:1] == 64'(i),
                $sformatf("stream ch%0d beat %0d", k, i),
                out_bits_w[k][64:1], 118'(i));
            chk(in_ready_w[k] == 1'b1, $sformatf("stream ch%0d ready %0d", k, i),
                118'(in_ready_w[k]), 118'(1));
         end
      end
      in_valid[1] = 1'b0;
      in_valid[3] = 1'b0;
      tick();
      out_ready[1] = 1'b0;
      out_ready[3] = 1'b0;

      // Asynchronous reset with one A entry held
      in_valid[0] = 1'b1;
      in_bits[0]  = b1;
      tick();
      in_valid[0] = 1'b0;
      chk(out_valid_w[0] == 1'b1, "pre-reset held", 118'(out_valid_w[0]), 118'(1));
      #1 reset = 1'b1;
      #1;
      chk(out_valid_w[0] == 1'b0, "async reset valid", 118'(out_valid_w[0]), 118'(0));
      chk(in_ready_w[0] == 1'b1, "async reset ready", 118'(in_ready_w[0]), 118'(1));
      tick();
      reset = 1'b0;
      tick();

      // Random traffic with random backpressure, all four channels at once
      for (int k = 0; k < 4; k++) begin
         sent[k]    = 0;
         recv[k]    = 0;
         to_send[k] = 1000;
      end
      cyc  = 0;
      busy = 1'b1;
      while (busy && cyc < 20000) begin
         for (int k = 0; k < 4; k++) begin
            if (!in_valid[k] || acc[k]) begin
               if (to_send[k] > 0 && $urandom_range(0, 3) != 0) begin
                  r = {$urandom, $urandom, $urandom, $urandom};
                  in_bits[k]  = r[117:0] & wmask(k);
                  in_valid[k] = 1'b1;
                  to_send[k]--;
               end else begin
                  in_valid[k] = 1'b0;
               end
            end
            out_ready[k] = ($urandom_range(0, 2) != 0);
         end
         tick();
         cyc++;
         busy = 1'b0;
         for (int k = 0; k < 4; k++)
            if (to_send[k] > 0 || in_valid[k] || mq[k].size() != 0) busy = 1'b1;
      end
      chk(!busy, "random completion", 118'(busy), 118'(0));
      for (int k = 0; k < 4; k++) begin
         in_valid[k]  = 1'b0;
         out_ready[k] = 1'b0;
      end
      tick();
      for (int k = 0; k < 4; k++)
         chk(recv[k] == 1000 && sent[k] == 1000, $sformatf("ch%0d delivered", k),
             118'(recv[k]), 118'(1000));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
